// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target endpoint, 7-bit address, byte RX/TX; optional clock stretching via I2C_TARGET_CLK_STRETCH_EN
module i2c_target #(
  parameter logic [6:0] ADDR        = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       scl_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_load,
  output logic       busy,
  output logic       addr_hit,
  output logic       rw
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_RX, ST_RX_ACK, ST_TX, ST_TX_ACK, ST_WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_d, sda_d;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start, stop;
  logic                   tx_enter;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       ack_on;
  logic       scl_hold;
  logic       tx_wait;

  // Synchronise the pads; reset to 1 so an idle bus produces no spurious events
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  // SCL must be high and stable on both samples, so an SDA edge alongside an SCL edge is data
  assign start    = scl_s & scl_d & ~sda_s & sda_d;
  assign stop     = scl_s & scl_d & sda_s & ~sda_d;

  // The SCL fall that closes an address ACK (read) or a master ACK starts the next read byte
  assign tx_enter = scl_fall & ack_on & (((state == ST_ADDR_ACK) & rw) | (state == ST_TX_ACK));

  assign scl_oe = scl_hold;

  // Protocol FSM with registered pad drives and client strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      bit_cnt  <= 3'd7;
      shreg    <= 8'h00;
      ack_on   <= 1'b0;
      sda_oe   <= 1'b0;
      scl_hold <= 1'b0;
      tx_wait  <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_load  <= 1'b0;
      busy     <= 1'b0;
      addr_hit <= 1'b0;
      rw       <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_load  <= 1'b0;
      if (stop) begin
        state    <= ST_IDLE;
        sda_oe   <= 1'b0;
        scl_hold <= 1'b0;
        tx_wait  <= 1'b0;
        busy     <= 1'b0;
        addr_hit <= 1'b0;
        ack_on   <= 1'b0;
      end else if (start) begin
        state    <= ST_ADDR;
        bit_cnt  <= 3'd7;
        sda_oe   <= 1'b0;
        scl_hold <= 1'b0;
        tx_wait  <= 1'b0;
        busy     <= 1'b1;
        addr_hit <= 1'b0;
        ack_on   <= 1'b0;
      end else if (tx_enter) begin
        state   <= ST_TX;
        bit_cnt <= 3'd7;
        ack_on  <= 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
        if (!tx_valid) begin
          sda_oe   <= 1'b0;
          scl_hold <= 1'b1;
          tx_wait  <= 1'b1;
        end else
`endif
        begin
          tx_load <= 1'b1;
          shreg   <= tx_data;
          sda_oe  <= ~tx_data[7];
        end
      end else begin
        case (state)
          ST_ADDR: if (scl_rise) begin
            shreg <= {shreg[6:0], sda_s};
            if (bit_cnt == 3'd0) begin
              if (shreg[6:0] == ADDR) begin
                rw       <= sda_s;
                addr_hit <= 1'b1;
                ack_on   <= 1'b0;
                state    <= ST_ADDR_ACK;
              end else begin
                state <= ST_WAIT_STOP;
              end
            end else begin
              bit_cnt <= bit_cnt - 3'd1;
            end
          end
          ST_ADDR_ACK, ST_RX_ACK: if (scl_fall) begin
            // First fall pulls SDA for the ACK slot, second fall releases it
            if (!ack_on) begin
              sda_oe <= 1'b1;
              ack_on <= 1'b1;
            end else begin
              sda_oe  <= 1'b0;
              ack_on  <= 1'b0;
              bit_cnt <= 3'd7;
              state   <= ST_RX;
            end
          end
          ST_RX: if (scl_rise) begin
            shreg <= {shreg[6:0], sda_s};
            if (bit_cnt == 3'd0) begin
              rx_data  <= {shreg[6:0], sda_s};
              rx_valid <= 1'b1;
              ack_on   <= 1'b0;
              state    <= ST_RX_ACK;
            end else begin
              bit_cnt <= bit_cnt - 3'd1;
            end
          end
          ST_TX: begin
            if (tx_wait) begin
              if (tx_valid) begin
                tx_load <= 1'b1;
                shreg   <= tx_data;
                sda_oe  <= ~tx_data[7];
                tx_wait <= 1'b0;
              end
            end else begin
              // Bit 7 is on the line by now, so the stretch can end
              scl_hold <= 1'b0;
              if (scl_fall) begin
                if (bit_cnt == 3'd0) begin
                  sda_oe <= 1'b0;
                  ack_on <= 1'b0;
                  state  <= ST_TX_ACK;
                end else begin
                  bit_cnt <= bit_cnt - 3'd1;
                  shreg   <= {shreg[6:0], 1'b0};
                  sda_oe  <= ~shreg[6];
                end
              end
            end
          end
          ST_TX_ACK: if (scl_rise) begin
            if (sda_s) state <= ST_WAIT_STOP;
            else       ack_on <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - directed scoreboard bench for i2c_target
module tb_i2c_target;
  localparam int Q = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b1;
  logic       scl_i, sda_i;
  logic       sda_oe, scl_oe, rx_valid, tx_load, busy, addr_hit, rw;
  logic [7:0] rx_data;

  int vectors = 0;
  int errors  = 0;
  int rx_cnt  = 0;
  int ld_cnt  = 0;
  bit sda_seen = 1'b0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_rd[$];

  assign scl_i = scl_m & ~scl_oe;
  assign sda_i = sda_m & ~sda_oe;

  i2c_target dut (
    .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe), .scl_oe(scl_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_load(tx_load), .busy(busy), .addr_hit(addr_hit), .rw(rw)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      check("rx_pending", {31'd0, exp_rx.size() > 0}, 32'd1);
      if (exp_rx.size() > 0) check("rx_data_sb", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
    end
    if (tx_load) ld_cnt++;
    if (sda_oe) sda_seen = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_scl_high();
    for (int i = 0; i < 400 && !scl_i; i++) tick(1);
    if (!scl_i) check("scl_release_timeout", {31'd0, scl_i}, 32'd1);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; tick(Q);
    scl_m = 1'b1; wait_scl_high(); tick(2 * Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; wait_scl_high(); tick(Q);
    b = sda_i; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack_n);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack_n);
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
  endtask

  task automatic start_c();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic stop_c();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  initial begin
    logic       a;
    logic [7:0] d;
    int         c0;
    int         l0;

    tick(3);
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_scl_oe", {31'd0, scl_oe}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_addr_hit", {31'd0, addr_hit}, 32'd0);
    check("rst_rw", {31'd0, rw}, 32'd0);
    rst = 1'b0;
    tick(4);

    // Write 0x3C to 0x50
    c0 = rx_cnt;
    start_c();
    check("wr_busy_start", {31'd0, busy}, 32'd1);
    write_byte(8'hA0, a);
    check("wr_addr_ack", {31'd0, a}, 32'd0);
    check("wr_addr_hit", {31'd0, addr_hit}, 32'd1);
    check("wr_rw", {31'd0, rw}, 32'd0);
    exp_rx.push_back(8'h3C);
    write_byte(8'h3C, a);
    check("wr_data_ack", {31'd0, a}, 32'd0);
    stop_c();
    check("wr_rx_data", {24'd0, rx_data}, 32'h3C);
    check("wr_rx_pulses", rx_cnt - c0, 32'd1);
    check("wr_busy_stop", {31'd0, busy}, 32'd0);
    check("wr_hit_stop", {31'd0, addr_hit}, 32'd0);

    // Read two bytes, ACK then NACK
    l0 = ld_cnt;
    tx_data = 8'h5A; exp_rd.push_back(8'h5A);
    start_c();
    write_byte(8'hA1, a);
    check("rd_addr_ack", {31'd0, a}, 32'd0);
    check("rd_rw", {31'd0, rw}, 32'd1);
    read_byte(d);
    check("rd_byte1", {24'd0, d}, {24'd0, exp_rd.pop_front()});
    tx_data = 8'hC3; exp_rd.push_back(8'hC3);
    write_bit(1'b0);
    read_byte(d);
    check("rd_byte2", {24'd0, d}, {24'd0, exp_rd.pop_front()});
    write_bit(1'b1);
    check("rd_sda_released", {31'd0, sda_oe}, 32'd0);
    stop_c();
    check("rd_tx_loads", ld_cnt - l0, 32'd2);

    // Address miss
    c0 = rx_cnt;
    sda_seen = 1'b0;
    start_c();
    write_byte(8'h62, a);
    check("miss_addr_nack", {31'd0, a}, 32'd1);
    write_byte(8'hFF, a);
    check("miss_data_nack", {31'd0, a}, 32'd1);
    check("miss_addr_hit", {31'd0, addr_hit}, 32'd0);
    stop_c();
    check("miss_sda_never", {31'd0, sda_seen}, 32'd0);
    check("miss_rx_pulses", rx_cnt - c0, 32'd0);

    // Write then repeated START into a one-byte read
    c0 = rx_cnt;
    start_c();
    write_byte(8'hA0, a);
    check("sr_addr_w_ack", {31'd0, a}, 32'd0);
    exp_rx.push_back(8'h10);
    write_byte(8'h10, a);
    check("sr_data_ack", {31'd0, a}, 32'd0);
    tx_data = 8'h96; exp_rd.push_back(8'h96);
    start_c();
    write_byte(8'hA1, a);
    check("sr_addr_r_ack", {31'd0, a}, 32'd0);
    check("sr_rw", {31'd0, rw}, 32'd1);
    read_byte(d);
    check("sr_rd_byte", {24'd0, d}, {24'd0, exp_rd.pop_front()});
    write_bit(1'b1);
    stop_c();
    check("sr_rx_data", {24'd0, rx_data}, 32'h10);
    check("sr_rx_pulses", rx_cnt - c0, 32'd1);

    // Reset while driving a read bit
    tx_data = 8'h00;
    start_c();
    write_byte(8'hA1, a);
    check("rr_addr_ack", {31'd0, a}, 32'd0);
    for (int i = 0; i < 50 && !sda_oe; i++) tick(1);
    check("rr_sda_driven", {31'd0, sda_oe}, 32'd1);
    rst = 1'b1;
    #1;
    check("rr_sda_async", {31'd0, sda_oe}, 32'd0);
    check("rr_busy", {31'd0, busy}, 32'd0);
    check("rr_addr_hit", {31'd0, addr_hit}, 32'd0);
    tick(2);
    rst = 1'b0;
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
    c0 = rx_cnt;
    start_c();
    write_byte(8'hA0, a);
    check("rr_next_addr_ack", {31'd0, a}, 32'd0);
    exp_rx.push_back(8'hA5);
    write_byte(8'hA5, a);
    check("rr_next_data_ack", {31'd0, a}, 32'd0);
    stop_c();
    check("rr_next_rx_data", {24'd0, rx_data}, 32'hA5);
    check("rr_next_rx_pulses", rx_cnt - c0, 32'd1);
    check("rx_queue_drained", exp_rx.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
